// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshakes.
// The operands are split into CHUNK-bit slices. Each stage ripples one slice
// as it loads and registers the carry for the next stage. The last stage's
// registers drive sum/cout/ovf directly.
module pipelined_rca_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    // Chain of full-adder cells. Returns {carry into MSB cell, carry out, sum}.
    function automatic logic [CHUNK+1:0] ripple(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        logic [CHUNK-1:0] s;
        logic             c;
        logic             c_msb;
        s     = '0;
        c     = ci;
        c_msb = ci;
        for (int i = 0; i < int'(CHUNK); i++) begin
            c_msb = c;
            s[i]  = x[i] ^ y[i] ^ c;
            c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c_msb, c, s};
    endfunction

    // Per-stage state: valid bit, operands (a and the effective b), partial
    // result, and the carry out of the slice this stage has computed.
    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q;
    logic [STAGES-1:0]            c_q;
    logic                         ovf_q;

    logic [STAGES:0]              ready;
    logic [STAGES-1:0]            valid_src;
    logic [STAGES-1:0]            c_src;
    logic [STAGES-1:0]            c_d;
    logic [STAGES-1:0]            cm_d;
    logic [STAGES-1:0][WIDTH-1:0] a_src;
    logic [STAGES-1:0][WIDTH-1:0] b_src;
    logic [STAGES-1:0][WIDTH-1:0] s_src;
    logic [STAGES-1:0][WIDTH-1:0] s_d;

    // Ready ripples combinationally upstream from out_ready; empty stages always accept
    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            ready[k] = !valid_q[k] || ready[k+1];
        end
    end

    // What each stage would load: stage 0 takes the transformed inputs, others the stage before
    always_comb begin
        valid_src    = '0;
        c_src        = '0;
        a_src        = '0;
        b_src        = '0;
        s_src        = '0;
        valid_src[0] = in_valid;
        a_src[0]     = a;
        b_src[0]     = sub ? ~b : b;
        c_src[0]     = sub | cin;
        for (int k = 1; k < int'(STAGES); k++) begin
            valid_src[k] = valid_q[k-1];
            a_src[k]     = a_q[k-1];
            b_src[k]     = b_q[k-1];
            s_src[k]     = s_q[k-1];
            c_src[k]     = c_q[k-1];
        end
    end

    // Each stage ripples its own slice on the way into its registers
    always_comb begin
        s_d  = s_src;
        c_d  = '0;
        cm_d = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            {cm_d[k], c_d[k], s_d[k][k*int'(CHUNK) +: CHUNK]} =
                ripple(a_src[k][k*int'(CHUNK) +: CHUNK], b_src[k][k*int'(CHUNK) +: CHUNK],
                       c_src[k]);
        end
    end

    // Stage registers: a stage loads when ready, otherwise holds everything unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_src[k];
                    if (valid_src[k]) begin
                        a_q[k] <= a_src[k];
                        b_q[k] <= b_src[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
            if (ready[STAGES-1] && valid_src[STAGES-1]) begin
                ovf_q <= cm_d[STAGES-1] ^ c_d[STAGES-1];
            end
        end
    end

    // Operand slices that have already been consumed are dead
    logic unused_dead;
    assign unused_dead = ^{a_q, b_q, a_src, b_src, cm_d};

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench for pipelined_rca_adder (WIDTH=16, CHUNK=4, latency 4).
// A scoreboard queue holds {sum,cout,ovf} plus acceptance cycle for every accepted beat.
module tb_pipelined_rca_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CHUNK = 4;
    localparam int          LAT   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    pipelined_rca_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [17:0] res;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [17:0] pending;

    // Observations of one cycle, taken on the falling edge
    bit          obs_acc;
    bit          obs_del;
    bit          obs_vld;
    bit          obs_rdy;
    bit          obs_unexp;
    logic [17:0] obs_got;
    logic [17:0] obs_exp;
    int          obs_lat;

    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
        logic [15:0] yy;
        logic [16:0] r;
        logic        ov;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {16'b0, (s ? 1'b1 : ci)};
        ov = (x[15] == yy[15]) && (r[15] != x[15]);
        return {r[15:0], r[16], ov};
    endfunction

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic s, input logic [17:0] e);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        pending  = e;
    endtask

    // One clock cycle: sample handshakes, update the scoreboard, return at posedge+1
    task automatic step();
        exp_t e;
        @(negedge clk);
        obs_acc   = in_valid && in_ready;
        obs_del   = out_valid && out_ready;
        obs_vld   = out_valid;
        obs_rdy   = in_ready;
        obs_got   = {sum, cout, ovf};
        obs_exp   = '0;
        obs_lat   = -1;
        obs_unexp = 1'b0;
        if (obs_del) begin
            if (q.size() == 0) begin
                obs_unexp = 1'b1;
            end else begin
                e       = q.pop_front();
                obs_exp = e.res;
                obs_lat = cyc - e.cyc;
            end
        end
        if (obs_acc) q.push_back('{pending, cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({sum, cout, ovf} !== 18'h0) begin
            n_fail++; $display("FAIL reset outputs: got sum=%h cout=%b ovf=%b expected 0", sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_vld !== 1'b0) begin
                n_fail++; $display("FAIL reset idle out_valid: got %b expected 0", obs_vld);
            end
        end
    endtask

    task automatic test_add_wrap();
        out_ready = 1'b1;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
        step();
        n_checks++;
        if (!obs_acc) begin n_fail++; $display("FAIL add_wrap accept: got 0 expected 1"); end
        in_valid = 1'b0;
        for (int i = 0; i < 12 && q.size() > 0; i++) begin
            step();
            if (obs_del) begin
                n_checks++;
                if (obs_unexp || obs_got !== obs_exp) begin
                    n_fail++; $display("FAIL add_wrap result {sum,cout,ovf}: got %h expected %h", obs_got, obs_exp);
                end
                n_checks++;
                if (obs_lat != LAT) begin
                    n_fail++; $display("FAIL add_wrap latency: got %0d expected %0d", obs_lat, LAT);
                end
            end
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL add_wrap drain: got %0d pending expected 0", q.size()); q.delete();
        end
    endtask

    task automatic test_overflow_cin();
        out_ready = 1'b1;
        drive(16'h7FFF, 16'h0000, 1'b1, 1'b0, {16'h8000, 1'b0, 1'b1});
        step();
        drive(16'h8000, 16'h8000, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b1});
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 12 && q.size() > 0; i++) begin
            step();
            if (obs_del) begin
                n_checks++;
                if (obs_unexp || obs_got !== obs_exp) begin
                    n_fail++; $display("FAIL overflow result {sum,cout,ovf}: got %h expected %h", obs_got, obs_exp);
                end
                n_checks++;
                if (obs_lat != LAT) begin
                    n_fail++; $display("FAIL overflow latency: got %0d expected %0d", obs_lat, LAT);
                end
            end
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL overflow drain: got %0d pending expected 0", q.size()); q.delete();
        end
    endtask

    task automatic test_subtract();
        out_ready = 1'b1;
        drive(16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0});
        step();
        drive(16'h0007, 16'h0005, 1'b0, 1'b1, {16'h0002, 1'b1, 1'b0});
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 12 && q.size() > 0; i++) begin
            step();
            if (obs_del) begin
                n_checks++;
                if (obs_unexp || obs_got !== obs_exp) begin
                    n_fail++; $display("FAIL subtract result {sum,cout,ovf}: got %h expected %h", obs_got, obs_exp);
                end
            end
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL subtract drain: got %0d pending expected 0", q.size()); q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] x, y;
        logic        ci, s;
        int          issued = 0;
        int          seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 64 + 20 && (issued < 64 || q.size() > 0); i++) begin
            if (issued < 64) begin
                x  = 16'($urandom);
                y  = 16'($urandom);
                ci = 1'($urandom);
                s  = 1'($urandom);
                drive(x, y, ci, s, model(x, y, ci, s));
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (in_valid) begin
                n_checks++;
                if (!obs_rdy) begin
                    n_fail++; $display("FAIL stream in_ready: got 0 expected 1 at beat %0d", issued);
                end
            end
            if (obs_acc) issued++;
            if (obs_del) begin
                seen++;
                n_checks++;
                if (obs_unexp || obs_got !== obs_exp) begin
                    n_fail++; $display("FAIL stream result %0d {sum,cout,ovf}: got %h expected %h", seen, obs_got, obs_exp);
                end
                n_checks++;
                if (obs_lat != LAT) begin
                    n_fail++; $display("FAIL stream latency %0d: got %0d expected %0d", seen, obs_lat, LAT);
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (seen != 64) begin
            n_fail++; $display("FAIL stream count: got %0d results expected 64", seen); q.delete();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] x, y;
        logic        ci, s;
        int          n_acc = 0;
        int          seen = 0;
        bit          have_hold = 1'b0;
        logic [17:0] held = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            x  = 16'($urandom);
            y  = 16'($urandom);
            ci = 1'($urandom);
            s  = 1'($urandom);
            drive(x, y, ci, s, model(x, y, ci, s));
            step();
            if (obs_acc) n_acc++;
            if (obs_vld) begin
                if (!have_hold) begin
                    held      = obs_got;
                    have_hold = 1'b1;
                end else begin
                    n_checks++;
                    if (obs_got !== held) begin
                        n_fail++; $display("FAIL backpressure hold: got %h expected %h", obs_got, held);
                    end
                end
            end
        end
        n_checks++;
        if (n_acc != 4) begin
            n_fail++; $display("FAIL backpressure accepted: got %0d expected 4", n_acc);
        end
        n_checks++;
        if (obs_rdy !== 1'b0) begin
            n_fail++; $display("FAIL backpressure in_ready when full: got %b expected 0", obs_rdy);
        end
        n_checks++;
        if (!have_hold) begin
            n_fail++; $display("FAIL backpressure out_valid: got 0 expected 1");
        end
        // Release on a full pipe: one result leaves and one beat enters in the same cycle
        out_ready = 1'b1;
        x = 16'($urandom);
        y = 16'($urandom);
        drive(x, y, 1'b0, 1'b1, model(x, y, 1'b0, 1'b1));
        step();
        n_checks++;
        if (!(obs_acc && obs_del)) begin
            n_fail++; $display("FAIL backpressure release: got acc=%b del=%b expected 1 1", obs_acc, obs_del);
        end
        if (obs_del) begin
            seen++;
            n_checks++;
            if (obs_unexp || obs_got !== obs_exp) begin
                n_fail++; $display("FAIL backpressure result %0d: got %h expected %h", seen, obs_got, obs_exp);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12 && q.size() > 0; i++) begin
            step();
            if (obs_del) begin
                seen++;
                n_checks++;
                if (obs_unexp || obs_got !== obs_exp) begin
                    n_fail++; $display("FAIL backpressure result %0d: got %h expected %h", seen, obs_got, obs_exp);
                end
            end
        end
        n_checks++;
        if (seen != 5 || q.size() != 0) begin
            n_fail++; $display("FAIL backpressure drain: got %0d results expected 5", seen); q.delete();
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(16'h1234, 16'h4321, 1'b0, 1'b0, model(16'h1234, 16'h4321, 1'b0, 1'b0));
        step();
        drive(16'hAAAA, 16'h5555, 1'b1, 1'b0, model(16'hAAAA, 16'h5555, 1'b1, 1'b0));
        step();
        drive(16'h0F0F, 16'h00FF, 1'b0, 1'b1, model(16'h0F0F, 16'h00FF, 1'b0, 1'b1));
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if (q.size() != 3) begin
            n_fail++; $display("FAIL midreset in flight: got %0d expected 3", q.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if ({sum, cout, ovf} !== 18'h0) begin
            n_fail++; $display("FAIL midreset outputs: got sum=%h cout=%b ovf=%b expected 0", sum, cout, ovf);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset in_ready: got %b expected 1", in_ready);
        end
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(16'h0100, 16'h0023, 1'b1, 1'b0, model(16'h0100, 16'h0023, 1'b1, 1'b0));
        step();
        n_checks++;
        if (!obs_acc) begin n_fail++; $display("FAIL midreset new accept: got 0 expected 1"); end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_del) begin
                n_checks++;
                if (obs_unexp || obs_got !== obs_exp) begin
                    n_fail++; $display("FAIL midreset result: got %h expected %h stale=%b", obs_got, obs_exp, obs_unexp);
                end
                n_checks++;
                if (!obs_unexp && obs_lat != LAT) begin
                    n_fail++; $display("FAIL midreset latency: got %0d expected %0d", obs_lat, LAT);
                end
            end
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL midreset drain: got %0d pending expected 0", q.size()); q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_overflow_cin();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "time limit");
    end

endmodule
